// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master controller.
//   i2c_state_e : controller state encoding
//   PH_Q0..Q3   : quarter-period phase codes produced by i2c_clk_div
//   SLAVE_ADDR  : 7-bit address of the team's reference slave
//   BIT_MSB     : start value of the per-byte bit counter
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    RNACK,
    STOP
  } i2c_state_e;

  // Q0: SCL low, SDA updated; Q1: SCL released; Q2: SDA sampled; Q3: SCL low
  localparam logic [1:0] PH_Q0 = 2'd0;
  localparam logic [1:0] PH_Q1 = 2'd1;
  localparam logic [1:0] PH_Q2 = 2'd2;
  localparam logic [1:0] PH_Q3 = 2'd3;

  localparam logic [6:0] SLAVE_ADDR = 7'b1000100;

  localparam logic [2:0] BIT_MSB = 3'd7;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator for the I2C master.
// While en is high, tick pulses for one clk every CLK_DIV clks and phase
// advances Q0->Q1->Q2->Q3->Q0 after each tick. phase names the quarter that
// the current tick executes. Dropping en returns the divider to count 0 / Q0
// so every transaction starts bit-aligned.
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : run enable (controller busy)
//   tick       : one-clk quarter-period strobe
//   phase[1:0] : quarter index for the current tick
import i2c_pkg::*;

module i2c_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= PH_Q0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= PH_Q0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master (write or read one byte, 7-bit addressing).
// Each bit on the bus spans four quarter ticks from i2c_clk_div. The bus pins
// are open-drain: the controller only ever pulls low or releases.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : one-clk request; addr/rw/wdata captured when accepted
//   addr, rw   : 7-bit target address, 0 = write, 1 = read
//   wdata      : byte to write
//   rdata      : last byte read (held until the next completed read)
//   busy       : transaction in progress
//   done       : one-clk pulse at transaction end
//   ack_err    : slave NACKed address or data; valid with done
//   sda, scl   : open-drain I2C lines
import i2c_pkg::*;

module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  i2c_state_e state, state_nxt;

  logic       tick;
  logic [1:0] phase;
  logic [7:0] shift_q, shift_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic       rw_q, rw_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       scl_oe, scl_oe_nxt;
  logic       busy_nxt, done_nxt, ack_err_nxt;
  logic [7:0] rdata_nxt;
  logic       sda_in;

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (tick),
    .phase (phase)
  );

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign scl    = scl_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      bit_cnt <= BIT_MSB;
      sda_oe  <= 1'b0;
      scl_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      wdata_q <= wdata_nxt;
      rw_q    <= rw_nxt;
      bit_cnt <= bit_cnt_nxt;
      sda_oe  <= sda_oe_nxt;
      scl_oe  <= scl_oe_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      ack_err <= ack_err_nxt;
      rdata   <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    wdata_nxt   = wdata_q;
    rw_nxt      = rw_q;
    bit_cnt_nxt = bit_cnt;
    sda_oe_nxt  = sda_oe;
    scl_oe_nxt  = scl_oe;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    ack_err_nxt = ack_err;
    rdata_nxt   = rdata;

    case (state)
      IDLE: begin
        sda_oe_nxt = 1'b0;
        scl_oe_nxt = 1'b0;
        if (start && !busy) begin
          state_nxt   = START;
          busy_nxt    = 1'b1;
          ack_err_nxt = 1'b0;
          shift_nxt   = {addr, rw};
          wdata_nxt   = wdata;
          rw_nxt      = rw;
          bit_cnt_nxt = BIT_MSB;
        end
      end

      // SDA falls in the high half of the period, SCL follows at Q3
      START: begin
        if (tick) begin
          case (phase)
            PH_Q2: sda_oe_nxt = 1'b1;
            PH_Q3: begin
              scl_oe_nxt = 1'b1;
              state_nxt  = ADDR;
            end
            default: ;
          endcase
        end
      end

      // Both outgoing bytes share the shifter; wdata is loaded after the address ACK
      ADDR, WDATA: begin
        if (tick) begin
          case (phase)
            PH_Q0: sda_oe_nxt = ~shift_q[7];
            PH_Q1: scl_oe_nxt = 1'b0;
            PH_Q3: begin
              scl_oe_nxt = 1'b1;
              shift_nxt  = {shift_q[6:0], 1'b0};
              if (bit_cnt == 3'd0) begin
                bit_cnt_nxt = BIT_MSB;
                state_nxt   = (state == ADDR) ? ADDR_ACK : WACK;
              end else begin
                bit_cnt_nxt = bit_cnt - 3'd1;
              end
            end
            default: ;
          endcase
        end
      end

      // ack_err is set at Q2 and is already visible when Q3 decides the branch
      ADDR_ACK, WACK: begin
        if (tick) begin
          case (phase)
            PH_Q0: sda_oe_nxt = 1'b0;
            PH_Q1: scl_oe_nxt = 1'b0;
            PH_Q2: if (sda_in) ack_err_nxt = 1'b1;
            PH_Q3: begin
              scl_oe_nxt = 1'b1;
              if (state == WACK || ack_err) begin
                state_nxt = STOP;
              end else if (rw_q) begin
                state_nxt = RDATA;
              end else begin
                state_nxt = WDATA;
                shift_nxt = wdata_q;
              end
            end
            default: ;
          endcase
        end
      end

      RDATA: begin
        if (tick) begin
          case (phase)
            PH_Q0: sda_oe_nxt = 1'b0;
            PH_Q1: scl_oe_nxt = 1'b0;
            PH_Q2: shift_nxt  = {shift_q[6:0], sda_in};
            PH_Q3: begin
              scl_oe_nxt = 1'b1;
              if (bit_cnt == 3'd0) begin
                bit_cnt_nxt = BIT_MSB;
                rdata_nxt   = shift_q;
                state_nxt   = RNACK;
              end else begin
                bit_cnt_nxt = bit_cnt - 3'd1;
              end
            end
            default: ;
          endcase
        end
      end

      // Released SDA during the ninth bit tells the slave this is the last byte
      RNACK: begin
        if (tick) begin
          case (phase)
            PH_Q0: sda_oe_nxt = 1'b0;
            PH_Q1: scl_oe_nxt = 1'b0;
            PH_Q3: begin
              scl_oe_nxt = 1'b1;
              state_nxt  = STOP;
            end
            default: ;
          endcase
        end
      end

      // SDA low under low SCL, SCL released, then SDA rises while SCL is high
      STOP: begin
        if (tick) begin
          case (phase)
            PH_Q0: sda_oe_nxt = 1'b1;
            PH_Q1: scl_oe_nxt = 1'b0;
            PH_Q2: sda_oe_nxt = 1'b0;
            PH_Q3: begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
            default: ;
          endcase
        end
      end

      default: begin
        state_nxt  = IDLE;
        sda_oe_nxt = 1'b0;
        scl_oe_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

endmodule
